// File: rtl/sorted_way_streamer.sv
// -----------------------------------------------------------------------------
// sorted_way_streamer
//
// Captures one flattened, ascending-sorted vector of NUM_WAY ways in a single
// valid/ready handshake. It then emits the ways one per handshake, smallest
// slot first, with the slot index and a last marker on each element.
//
// Optional feature: define SORTED_WAY_STREAMER_DEDUP_EN to suppress repeated
// values. After emitting a way, the stream skips every following slot that
// holds the same value. The last marker then flags the element equal to the
// final slot's value.
//
// Ports:
//   clk_in             single clock, rising edge
//   reset_n_in         synchronous, active-low reset
//   sorted_flatted_in  sorted vector; way k = bits [k*W +: W], way 0 smallest
//   sorted_valid_in    vector valid
//   sorted_ready_out   block can capture a vector (idle)
//   way_data_out       current element (0 when not valid)
//   way_index_out      slot of the current element (0 when not valid)
//   way_valid_out      element valid
//   way_ready_in       downstream accepts the element
//   way_last_out       current element ends this vector (0 when not valid)
//   busy_out           streaming in progress
// -----------------------------------------------------------------------------
module sorted_way_streamer #(
  parameter  int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter  int NUM_WAY                  = 16,
  localparam int WAY_INDEX_WIDTH          = $clog2(NUM_WAY)
) (
  input  logic                                        clk_in,
  input  logic                                        reset_n_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] sorted_flatted_in,
  input  logic                                        sorted_valid_in,
  output logic                                        sorted_ready_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         way_data_out,
  output logic [WAY_INDEX_WIDTH-1:0]                  way_index_out,
  output logic                                        way_valid_out,
  input  logic                                        way_ready_in,
  output logic                                        way_last_out,
  output logic                                        busy_out
);

  localparam int W     = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int VEC_W = SINGLE_WAY_WIDTH_IN_BITS * NUM_WAY;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [WAY_INDEX_WIDTH-1:0] index_q, index_d;
  logic [VEC_W-1:0]           vector_q, vector_d;

  logic [W-1:0]               cur_way;
  logic [WAY_INDEX_WIDTH-1:0] next_index;
  logic                       is_last;

  assign cur_way = vector_q[index_q*W +: W];

`ifdef SORTED_WAY_STREAMER_DEDUP_EN
  logic [W-1:0] final_way;

  assign final_way = vector_q[(NUM_WAY-1)*W +: W];

  // Priority search for the lowest slot above the current one that holds a
  // different value. The loop runs downward so the lowest match is written last.
  // If no slot differs, the current element already equals the final way, so
  // is_last is set and next_index is never used.
  always_comb begin
    next_index = index_q;
    for (int j = NUM_WAY - 1; j > 0; j--) begin
      if ((WAY_INDEX_WIDTH'(j) > index_q) && (vector_q[j*W +: W] != cur_way)) begin
        next_index = WAY_INDEX_WIDTH'(j);
      end
    end
  end

  assign is_last = (cur_way == final_way);
`else
  // The last slot ends the vector before the increment could wrap.
  assign next_index = index_q + WAY_INDEX_WIDTH'(1);
  assign is_last    = (index_q == WAY_INDEX_WIDTH'(NUM_WAY - 1));
`endif

  // NOTE: every signal written here gets a default first. Any path that leaves
  // a combinational output unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        if (sorted_valid_in) begin
          vector_d = sorted_flatted_in;
          index_d  = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // The captured vector is frozen here; the input bus is ignored.
        if (way_ready_in) begin
          if (is_last) begin
            index_d = '0;
            state_d = IDLE;
          end else begin
            index_d = next_index;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. This makes
  // every flop sample its _d value from before the edge.
  // NOTE: the captured vector is a plain register, not a RAM, so it is cleared
  // on reset. That keeps way_data_out at zero in the post-reset state.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      index_q  <= '0;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      vector_q <= vector_d;
    end
  end

  // Outputs decode registered state only. Data outputs read zero outside STREAM.
  assign sorted_ready_out = (state_q == IDLE);
  assign way_valid_out    = (state_q == STREAM);
  assign busy_out         = (state_q == STREAM);
  assign way_data_out     = way_valid_out ? cur_way : '0;
  assign way_index_out    = way_valid_out ? index_q : '0;
  assign way_last_out     = way_valid_out & is_last;

endmodule

// File: tb/tb_sorted_way_streamer.sv
// -----------------------------------------------------------------------------
// tb_sorted_way_streamer
//
// Self-checking bench for sorted_way_streamer with default parameters
// (4-bit ways, 16 ways). The expected beat list for each vector comes from a
// queue-based model of the stream rules. The same bench works with or without
// SORTED_WAY_STREAMER_DEDUP_EN.
// -----------------------------------------------------------------------------
module tb_sorted_way_streamer;

  localparam int W  = 4;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int VW = W * N;

  logic          clk_in = 1'b0;
  logic          reset_n_in;
  logic [VW-1:0] sorted_flatted_in;
  logic          sorted_valid_in;
  logic          sorted_ready_out;
  logic [W-1:0]  way_data_out;
  logic [IW-1:0] way_index_out;
  logic          way_valid_out;
  logic          way_ready_in;
  logic          way_last_out;
  logic          busy_out;

  sorted_way_streamer #(
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .NUM_WAY                 (N)
  ) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .sorted_flatted_in(sorted_flatted_in),
    .sorted_valid_in  (sorted_valid_in),
    .sorted_ready_out (sorted_ready_out),
    .way_data_out     (way_data_out),
    .way_index_out    (way_index_out),
    .way_valid_out    (way_valid_out),
    .way_ready_in     (way_ready_in),
    .way_last_out     (way_last_out),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Expected beats of the vector currently being streamed.
  logic [W-1:0]  exp_data[$];
  logic [IW-1:0] exp_index[$];
  logic          exp_last[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model of the beats one vector produces.
  // Without dedup, every slot is emitted in order.
  // With dedup, a slot is emitted when it starts a new run of equal values. The
  // stream ends at the first emitted value equal to the final slot's value.
  function automatic void build_model(input logic [VW-1:0] vec);
    logic [W-1:0] w[N];
    for (int k = 0; k < N; k++) w[k] = vec[k*W +: W];
    exp_data.delete();
    exp_index.delete();
    exp_last.delete();
`ifdef SORTED_WAY_STREAMER_DEDUP_EN
    for (int k = 0; k < N; k++) begin
      if (k == 0 || w[k] != w[k-1]) begin
        exp_data.push_back(w[k]);
        exp_index.push_back(IW'(k));
        exp_last.push_back(w[k] == w[N-1]);
        if (w[k] == w[N-1]) break;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      exp_data.push_back(w[k]);
      exp_index.push_back(IW'(k));
      exp_last.push_back(k == N - 1);
    end
`endif
  endfunction

  // Sink readiness per stream cycle: 0 always ready, 1 pattern 1,0,0,1, else random.
  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return ($urandom_range(0, 2) != 0);
    endcase
  endfunction

  // Call at a falling edge with the block idle. The task captures vec on the
  // next rising edge and then streams it.
  // hold_en keeps sorted_valid_in high and puts hold_vec on the bus during the
  // stream. stop_after >= 0 stops after that many beats, leaving the block
  // mid-stream.
  // A full stream returns at the falling edge after the last beat.
  task automatic stream_vector(input string tag, input logic [VW-1:0] vec, input int mode,
                               input logic hold_en, input logic [VW-1:0] hold_vec,
                               input int stop_after);
    int            beat;
    int            cyc;
    int            n;
    int            limit;
    logic          stalled;
    logic          r;
    logic [W-1:0]  held_d;
    logic [IW-1:0] held_i;
    logic          held_l;
    build_model(vec);
    n     = exp_data.size();
    limit = (stop_after >= 0 && stop_after < n) ? stop_after : n;
    sorted_flatted_in = vec;
    sorted_valid_in   = 1'b1;
    way_ready_in      = 1'b0;
    check({tag, "/cap_ready"}, 32'(sorted_ready_out), 32'd1);
    @(negedge clk_in);
    if (hold_en) sorted_flatted_in = hold_vec;
    else         sorted_valid_in   = 1'b0;
    check({tag, "/busy"}, 32'(busy_out), 32'd1);
    check({tag, "/ready_low"}, 32'(sorted_ready_out), 32'd0);
    beat    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_i  = '0;
    held_l  = 1'b0;
    while (beat < limit && cyc < 400) begin
      check({tag, "/valid"}, 32'(way_valid_out), 32'd1);
      if (!way_valid_out) break;
      if (stalled) begin
        check({tag, "/hold_data"}, 32'(way_data_out), 32'(held_d));
        check({tag, "/hold_index"}, 32'(way_index_out), 32'(held_i));
        check({tag, "/hold_last"}, 32'(way_last_out), 32'(held_l));
      end
      r = ready_for(mode, cyc);
      way_ready_in = r;
      if (r) begin
        check({tag, "/data"}, 32'(way_data_out), 32'(exp_data[beat]));
        check({tag, "/index"}, 32'(way_index_out), 32'(exp_index[beat]));
        check({tag, "/last"}, 32'(way_last_out), 32'(exp_last[beat]));
        beat++;
        stalled = 1'b0;
      end else begin
        held_d  = way_data_out;
        held_i  = way_index_out;
        held_l  = way_last_out;
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk_in);
    end
    check({tag, "/beats"}, 32'(beat), 32'(limit));
    way_ready_in = 1'b0;
    if (limit == n) begin
      check({tag, "/end_valid"}, 32'(way_valid_out), 32'd0);
      check({tag, "/end_ready"}, 32'(sorted_ready_out), 32'd1);
      check({tag, "/end_last"}, 32'(way_last_out), 32'd0);
    end
  endtask

  initial begin
    logic [VW-1:0] v_asc;
    logic [VW-1:0] v_rev;
    logic [VW-1:0] v_dup;
    logic [VW-1:0] v_seven;
    logic [VW-1:0] v;
    logic [W-1:0]  dup_vals[8];
    logic [W-1:0]  val;

    dup_vals = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hb, 4'hd, 4'hf};
    for (int k = 0; k < N; k++) begin
      v_asc[k*W +: W]   = W'(k);
      v_rev[k*W +: W]   = W'(N - 1 - k);
      v_dup[k*W +: W]   = dup_vals[k/2];
      v_seven[k*W +: W] = 4'h7;
    end

    // Reset with a vector offered at the same time; it must not be captured.
    reset_n_in        = 1'b0;
    sorted_valid_in   = 1'b1;
    sorted_flatted_in = v_asc;
    way_ready_in      = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst/ready", 32'(sorted_ready_out), 32'd1);
    check("rst/valid", 32'(way_valid_out), 32'd0);
    check("rst/last", 32'(way_last_out), 32'd0);
    check("rst/busy", 32'(busy_out), 32'd0);
    check("rst/data", 32'(way_data_out), 32'd0);
    check("rst/index", 32'(way_index_out), 32'd0);
    reset_n_in      = 1'b1;
    sorted_valid_in = 1'b0;
    @(negedge clk_in);
    check("idle/valid", 32'(way_valid_out), 32'd0);

    // Ascending vector, always ready.
    stream_vector("asc", v_asc, 0, 1'b0, '0, -1);
    @(negedge clk_in);

    // Backpressure 1,0,0,1.
    stream_vector("bp", v_asc, 1, 1'b0, '0, -1);
    @(negedge clk_in);

    // Duplicate pairs: all 16 beats without dedup, 8 beats with it.
    stream_vector("dup", v_dup, 0, 1'b0, '0, -1);
    stream_vector("dup_bp", v_dup, 2, 1'b0, '0, -1);

    // All ways equal.
    stream_vector("seven", v_seven, 0, 1'b0, '0, -1);
    @(negedge clk_in);

    // Reset after six beats; a vector offered during reset is dropped.
    stream_vector("mid", v_asc, 0, 1'b0, '0, 6);
    reset_n_in        = 1'b0;
    sorted_valid_in   = 1'b1;
    sorted_flatted_in = v_rev;
    @(negedge clk_in);
    check("midrst/valid", 32'(way_valid_out), 32'd0);
    check("midrst/ready", 32'(sorted_ready_out), 32'd1);
    check("midrst/busy", 32'(busy_out), 32'd0);
    check("midrst/last", 32'(way_last_out), 32'd0);
    check("midrst/data", 32'(way_data_out), 32'd0);
    check("midrst/index", 32'(way_index_out), 32'd0);
    reset_n_in      = 1'b1;
    sorted_valid_in = 1'b0;
    @(negedge clk_in);
    check("midrst/no_capture", 32'(way_valid_out), 32'd0);
    stream_vector("rev", v_rev, 0, 1'b0, '0, -1);
    @(negedge clk_in);

    // New vector held on the input during a stream. It must not disturb the
    // stream, and it must be captured on the edge right after the last beat.
    stream_vector("chg", v_asc, 1, 1'b1, v_dup, -1);
    stream_vector("chg_next", v_dup, 0, 1'b0, '0, -1);

    // Random vectors, sorted and unsorted, random sink readiness and gaps.
    for (int t = 0; t < 20; t++) begin
      if (t % 3 == 2) begin
        v = {$urandom, $urandom};
      end else begin
        val = W'($urandom_range(0, 3));
        for (int k = 0; k < N; k++) begin
          v[k*W +: W] = val;
          if ($urandom_range(0, 1) == 1 && val != 4'hf) val = val + 4'h1;
        end
      end
      stream_vector($sformatf("rnd%0d", t), v, 2, 1'b0, '0, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
